// File: rtl/uart_byte_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_tx_if : byte write request and transmitter status bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_byte_tx_if;
  logic [7:0] write_data;
  logic       write_en;
  logic       tx_busy;
  logic       uart_tx;
  logic       tx_drop;

  modport master (
    output write_data,
    output write_en,
    input  tx_busy,
    input  uart_tx,
    input  tx_drop
  );

  modport slave (
    input  write_data,
    input  write_en,
    output tx_busy,
    output uart_tx,
    output tx_drop
  );
endinterface
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_tx : LSB-first UART byte serialiser, optional parity/2 stop |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_byte_tx_if.slave bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam bit               HAS_PAR   = (PARITY != 0);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_byte_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_cnt_q;
  logic             tx_q;
  logic             busy_q;
  logic             drop_q;

  logic [CNT_W-1:0] baud_cnt_d;
  logic             baud_tc;

  assign baud_cnt_d = baud_cnt_q + CNT_W'(1);
  assign baud_tc    = (baud_cnt_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      par_q      <= 1'b0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // Rejection is judged on the pre-edge busy flag, including the edge busy falls on.
      drop_q <= bus.write_en & busy_q;

      case (state_q)
        S_IDLE: begin
          if (bus.write_en) begin
            data_q     <= bus.write_data;
            par_q      <= (^bus.write_data) ^ PAR_ODD;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (baud_tc) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= data_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end

        S_DATA: begin
          if (baud_tc) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              stop_cnt_q <= 1'b0;
              if (HAS_PAR) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end

        S_PARITY: begin
          if (baud_tc) begin
            baud_cnt_q <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end

        S_STOP: begin
          if (baud_tc) begin
            baud_cnt_q <= '0;
            if (stop_cnt_q == STOP_LAST) begin
              stop_cnt_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end

        default: begin
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_busy = busy_q;
  assign bus.uart_tx = tx_q;
  assign bus.tx_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// tb_uart_byte_tx : four transmitter configurations checked against a
// frame-level model (bit list built from the byte, parity rule and stop count).
module tb_uart_byte_tx;

  localparam int BD = 8;  // 80 Hz clock / 10 baud

  logic       clk;
  logic       rst_n;
  logic [3:0] we;
  logic [7:0] wd [4];
  logic [3:0] busy_w;
  logic [3:0] tx_w;
  logic [3:0] drop_w;

  int   checks = 0;
  int   fails  = 0;
  bit   exp_q[$];
  logic line_s [256];
  logic par_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance 0: no parity/1 stop, 1: even, 2: odd, 3: no parity/2 stop
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_byte_tx_if u_if ();
    assign u_if.write_data = wd[g];
    assign u_if.write_en   = we[g];
    assign busy_w[g]       = u_if.tx_busy;
    assign tx_w[g]         = u_if.uart_tx;
    assign drop_w[g]       = u_if.tx_drop;

    uart_byte_tx #(
      .CLK_FREQ (80),
      .BAUD_RATE(10),
      .PARITY   ((g == 1) ? 2 : (g == 2) ? 1 : 0),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int k, input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (k == 1) exp_q.push_back((ones % 2) == 1);
    if (k == 2) exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
    if (k == 3) exp_q.push_back(1'b1);
  endfunction

  // Called at a negedge with instance k idle; returns at the negedge where busy is seen low.
  task automatic send(input int k, input logic [7:0] b, input int inj, input string tag);
    int         f, c, drops, drop_c, mism;
    bit         done;
    logic [7:0] dec;
    model(k, b);
    f     = exp_q.size() * BD;
    wd[k] = b;
    we[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we[k]  = 1'b0;
    wd[k]  = 8'($urandom);
    c      = 0;
    drops  = 0;
    drop_c = -1;
    mism   = 0;
    done   = 1'b0;
    while (!done) begin
      we[k] = 1'b0;
      if (c < 256) line_s[c] = tx_w[k];
      if (c < f && tx_w[k] !== exp_q[c / BD]) mism++;
      if (drop_w[k]) begin
        drops++;
        drop_c = c;
      end
      if (!busy_w[k] || c >= f + 16) begin
        done = 1'b1;
      end else begin
        if (c == inj) begin
          wd[k] = 8'hFF;
          we[k] = 1'b1;
        end
        @(negedge clk);
        c++;
      end
    end
    check({tag, " busy_len"}, c, f);
    check({tag, " idle_line"}, {31'd0, tx_w[k]}, 1);
    check({tag, " line_trace"}, mism, 0);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s bit%0d", tag, i), {31'd0, line_s[i * BD + BD / 2]}, {31'd0, exp_q[i]});
    for (int j = 0; j < 8; j++) dec[j] = line_s[(1 + j) * BD + BD / 2];
    check({tag, " decoded"}, {24'd0, dec}, {24'd0, b});
    check({tag, " drop_count"}, drops, (inj >= 0) ? 1 : 0);
    if (inj >= 0) check({tag, " drop_cycle"}, drop_c, inj + 1);
    par_s = line_s[9 * BD + BD / 2];
  endtask

  initial begin
    int bad;
    rst_n = 1'b1;
    we    = 4'h0;
    for (int i = 0; i < 4; i++) wd[i] = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    check("rst uart_tx", {28'd0, tx_w}, 32'hF);
    check("rst tx_busy", {28'd0, busy_w}, 0);
    check("rst tx_drop", {28'd0, drop_w}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_w !== 4'hF || busy_w !== 4'h0 || drop_w !== 4'h0) bad++;
    end
    check("idle outputs", bad, 0);

    send(0, 8'h55, -1, "p0_55");

    send(1, 8'h07, -1, "even_07");
    check("even parity bit", {31'd0, par_s}, 1);
    send(2, 8'h07, -1, "odd_07");
    check("odd parity bit", {31'd0, par_s}, 0);

    send(3, 8'hA3, -1, "s2_A3");
    @(negedge clk);
    send(3, 8'h3C, -1, "s2_3C");

    send(0, 8'h41, 30, "drop_41");

    send(0, 8'($urandom), -1, "b2b_first");
    send(0, 8'($urandom), -1, "b2b_second");

    send(0, 8'($urandom), 79, "edge_reject");
    @(negedge clk);
    check("edge_reject not_accepted", {31'd0, busy_w[0]}, 0);
    check("edge_reject line", {31'd0, tx_w[0]}, 1);

    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 2; n++)
        send(k, 8'($urandom), -1, $sformatf("rnd%0d_%0d", k, n));

    @(negedge clk);
    wd[0] = 8'h96;
    we[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we[0] = 1'b0;
    repeat (35) @(negedge clk);
    check("pre_rst line", {31'd0, tx_w[0]}, 0);
    check("pre_rst busy", {31'd0, busy_w[0]}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst line", {31'd0, tx_w[0]}, 1);
    check("async_rst busy", {31'd0, busy_w[0]}, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || drop_w[0] !== 1'b0) bad++;
    end
    check("rst_hold outputs", bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h5A, -1, "post_rst_5A");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire
